alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// RV32I ALU-class decoder feeding a 2-entry issue FIFO towards the ALU stage.
// Define ALU_ISSUE_ILLEGAL_TRAP_EN to buffer unsupported instructions flagged as illegal.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic [4:0]  rd,
    output logic        illegal
);
    localparam int DATA_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam logic KEEP_ILLEGAL = 1'b1;
`else
    localparam logic KEEP_ILLEGAL = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        ctrl;
        logic [4:0]        rd;
        logic              ill;
    } entry_t;

    // The ALU shifts b by a[4:0], so shift operands are presented swapped.
    function automatic entry_t decode(input  logic [DATA_W-1:0] ins,
                                      input  logic [DATA_W-1:0] r1,
                                      input  logic [DATA_W-1:0] r2,
                                      output logic              sup);
        entry_t                   e;
        logic [2:0]               f3;
        logic [6:0]               f7;
        logic                     is_op;
        logic                     is_imm;
        logic                     shift;
        logic signed [DATA_W-1:0] imm_i;
        logic [DATA_W-1:0]        shamt_i;

        f3      = ins[14:12];
        f7      = ins[31:25];
        is_op   = (ins[6:0] == OPC_OP);
        is_imm  = (ins[6:0] == OPC_OP_IMM);
        imm_i   = {{20{ins[31]}}, ins[31:20]};
        shamt_i = {27'd0, ins[24:20]};
        e       = '0;
        e.rd    = ins[11:7];
        sup     = 1'b0;
        shift   = 1'b0;

        case (f3)
            3'b000: begin
                if (is_imm || (is_op && f7 == F7_BASE)) begin
                    e.ctrl = ALU_ADD;
                    sup    = 1'b1;
                end else if (is_op && f7 == F7_ALT) begin
                    e.ctrl = ALU_SUB;
                    sup    = 1'b1;
                end
            end
            3'b001: begin
                if ((is_op || is_imm) && f7 == F7_BASE) begin
                    e.ctrl = ALU_SLL;
                    sup    = 1'b1;
                    shift  = 1'b1;
                end
            end
            3'b010: begin
                if (is_imm || (is_op && f7 == F7_BASE)) begin
                    e.ctrl = ALU_SLT;
                    sup    = 1'b1;
                end
            end
            3'b101: begin
                if ((is_op || is_imm) && f7 == F7_BASE) begin
                    e.ctrl = ALU_SRL;
                    sup    = 1'b1;
                    shift  = 1'b1;
                end else if ((is_op || is_imm) && f7 == F7_ALT) begin
                    e.ctrl = ALU_SRA;
                    sup    = 1'b1;
                    shift  = 1'b1;
                end
            end
            3'b110: begin
                if (is_imm || (is_op && f7 == F7_BASE)) begin
                    e.ctrl = ALU_OR;
                    sup    = 1'b1;
                end
            end
            3'b111: begin
                if (is_imm || (is_op && f7 == F7_BASE)) begin
                    e.ctrl = ALU_AND;
                    sup    = 1'b1;
                end
            end
            default: ;
        endcase

        if (shift) begin
            e.a = is_op ? r2 : shamt_i;
            e.b = r1;
        end else begin
            e.a = r1;
            e.b = is_op ? r2 : imm_i;
        end

        if (!sup) begin
            e.a    = '0;
            e.b    = '0;
            e.ctrl = ALU_ADD;
            e.ill  = KEEP_ILLEGAL;
        end
        return e;
    endfunction

    // Stage p0: combinational decode of the incoming request
    entry_t dec_p0;
    logic   sup_p0;
    logic   push_p0;
    logic   pop_p0;
    logic   unused_rs1_field;

    always_comb begin
        dec_p0 = decode(instr, rs1_data, rs2_data, sup_p0);
    end

    assign unused_rs1_field = ^instr[19:15];

    // Stage p1: buffered entries and queue control
    entry_t     mem_p1 [2];
    entry_t     head_p1;
    logic [1:0] cnt_p1;
    logic [1:0] cnt_nxt;
    logic       wr_ptr_p1;
    logic       rd_ptr_p1;
    logic       ready_p1;
    logic       vld_p1;

    assign vld_p1   = (cnt_p1 != 2'd0);
    assign in_ready = ready_p1 & ~flush & ~rst;
    assign pop_p0   = vld_p1 & out_ready;
    assign push_p0  = in_valid & in_ready & (sup_p0 | KEEP_ILLEGAL);
    assign cnt_nxt  = cnt_p1 + {1'b0, push_p0} - {1'b0, pop_p0};
    assign head_p1  = mem_p1[rd_ptr_p1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1    <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
            ready_p1  <= 1'b0;
        end else if (flush) begin
            cnt_p1    <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
            ready_p1  <= 1'b1;
        end else begin
            cnt_p1   <= cnt_nxt;
            ready_p1 <= (cnt_nxt != 2'd2);
            if (push_p0) begin
                wr_ptr_p1 <= ~wr_ptr_p1;
            end
            if (pop_p0) begin
                rd_ptr_p1 <= ~rd_ptr_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) begin
            mem_p1[wr_ptr_p1] <= dec_p0;
        end
    end

    // Output: head entry, forced to zero whenever nothing is presented
    always_comb begin
        out_valid   = vld_p1;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        rd          = '0;
        illegal     = 1'b0;
        if (vld_p1) begin
            alu_a       = head_p1.a;
            alu_b       = head_p1.b;
            alu_control = head_p1.ctrl;
            rd          = head_p1.rd;
            illegal     = head_p1.ill;
        end
    end

endmodule
